// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: steps a registered 3-bit index through the enabled bits of en_mask,
// holding each channel dwell+1 cycles. Optional sweep counter under CHSEQ_SWEEP_CNT_EN.
module chan_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [7:0]         en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               sel_vld,
  output logic               busy,
  output logic               sweep_done
`ifdef CHSEQ_SWEEP_CNT_EN
  ,
  output logic [7:0]         sweep_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         hi_q, hi_d;
  logic               sel_vld_q, sel_vld_d;
  logic               busy_q, busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               hit_s;
  logic [2:0]         found_s;
  logic [2:0]         hi_idx_s;
  logic [2:0]         idx_s;
  logic               start_acc_s;

  // Circular search from ptr plus highest-set-bit of the live mask
  always_comb begin
    hit_s    = 1'b0;
    found_s  = 3'd0;
    hi_idx_s = 3'd0;
    idx_s    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx_s = ptr_q + i[2:0];
      if (!hit_s && en_mask[idx_s]) begin
        hit_s   = 1'b1;
        found_s = idx_s;
      end
      if (en_mask[i]) begin
        hi_idx_s = i[2:0];
      end
    end
  end

  assign start_acc_s = (state_q == IDLE) && start && !stop && (en_mask != 8'h00);

  // Next-state and next-output logic; outputs are predicted so they can be registered
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    hi_d    = hi_q;
    case (state_q)
      IDLE: begin
        if (start_acc_s) begin
          state_d = SEEK;
        end else begin
          state_d = IDLE;
        end
      end
      SEEK: begin
        if (hit_s) begin
          sel_d   = found_s;
          cnt_d   = dwell;
          hi_d    = hi_idx_s;
          state_d = DWELL;
        end else begin
          state_d = IDLE;
        end
      end
      DWELL: begin
        if (cnt_q != {DWELL_W{1'b0}}) begin
          cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
          ptr_d = sel_q + 3'd1;
          if (sel_q == hi_q) begin
            state_d = cont ? SEEK : IDLE;
          end else begin
            state_d = SEEK;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stop) begin
      state_d = IDLE;
      ptr_d   = 3'd0;
    end else begin
      ptr_d = ptr_d;
    end
    // The last cycle of the highest channel is the one where the counter will sit at zero
    sel_vld_d    = (state_d == DWELL);
    busy_d       = (state_d != IDLE);
    sweep_done_d = (state_d == DWELL) && (cnt_d == {DWELL_W{1'b0}}) && (sel_d == hi_d);
  end

`ifdef CHSEQ_SWEEP_CNT_EN
  logic [7:0] sweep_cnt_q, sweep_cnt_d;

  // Saturating sweep counter, cleared on an accepted start
  always_comb begin
    if (start_acc_s) begin
      sweep_cnt_d = 8'd0;
    end else if (sweep_done_d && (sweep_cnt_q != 8'hFF)) begin
      sweep_cnt_d = sweep_cnt_q + 8'd1;
    end else begin
      sweep_cnt_d = sweep_cnt_q;
    end
  end

  // Sweep counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt_q <= 8'd0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign sweep_cnt = sweep_cnt_q;
`endif

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 3'd0;
      cnt_q        <= {DWELL_W{1'b0}};
      sel_q        <= 3'd0;
      hi_q         <= 3'd0;
      sel_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      hi_q         <= hi_d;
      sel_vld_q    <= sel_vld_d;
      busy_q       <= busy_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign sel        = sel_q;
  assign sel_vld    = sel_vld_q;
  assign busy       = busy_q;
  assign sweep_done = sweep_done_q;

endmodule
